// File: rtl/tray_reader.sv
// tray_reader: launches one puzzle run, waits for the puzzle to halt, captures
// the marble tray and streams it out one marble per beat over a valid/ready
// interface, tallying red and blue marbles as they are accepted.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   go                    request a run (sampled only while idle)
//   start                 one-cycle pulse to the puzzle start input
//   stopped               puzzle halt indicator, asynchronous; any level change = halted
//   tray, tray_size       marble colours (1 = red) and number of valid marbles
//   m_valid/m_ready       marble beat handshake
//   m_data, m_last        colour of current beat, final-beat flag
//   count_red/count_blue  marbles accepted this run
//   busy                  high whenever not idle
//   timeout               sticky abort flag, cleared when the next go is accepted
module tray_reader #(
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        start,
  input  logic        stopped,
  input  logic [31:0] tray,
  input  logic [4:0]  tray_size,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_data,
  output logic        m_last,
  output logic [5:0]  count_red,
  output logic [5:0]  count_blue,
  output logic        busy,
  output logic        timeout
);

  // Wait counter counts 0 .. TIMEOUT-1; the cycle it holds TIMEOUT-1 is the last WAIT cycle.
  localparam int unsigned      CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]  WaitLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCapture,
    StStream,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic [CntW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]            tray_q, tray_d;
  logic [4:0]             size_q, size_d;
  logic [4:0]             idx_q, idx_d;
  logic [5:0]             cnt_red_q, cnt_red_d;
  logic [5:0]             cnt_blue_q, cnt_blue_d;
  logic                   timeout_q, timeout_d;

  logic stop_sync;
  logic beat_data;
  logic beat_last;

  assign stop_sync  = sync_q[SYNC_STAGES-1];
  assign beat_data  = tray_q[idx_q];
  assign beat_last  = (idx_q == size_q - 5'd1);
  assign busy       = (state_q != StIdle);
  assign count_red  = cnt_red_q;
  assign count_blue = cnt_blue_q;
  assign timeout    = timeout_q;

  always_comb begin
    sync_d[0] = stopped;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    wait_cnt_d = wait_cnt_q;
    tray_d     = tray_q;
    size_d     = size_q;
    idx_d      = idx_q;
    cnt_red_d  = cnt_red_q;
    cnt_blue_d = cnt_blue_q;
    timeout_d  = timeout_q;
    start      = 1'b0;
    m_valid    = 1'b0;
    m_data     = 1'b0;
    m_last     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d    = StLaunch;
          cnt_red_d  = '0;
          cnt_blue_d = '0;
          timeout_d  = 1'b0;
        end
      end
      StLaunch: begin
        start      = 1'b1;
        // Halt is signalled by any change relative to the level seen at launch.
        ref_d      = stop_sync;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (stop_sync != ref_q) begin
          state_d = StCapture;
        end else if (wait_cnt_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        tray_d  = tray;
        size_d  = tray_size;
        idx_d   = '0;
        state_d = (tray_size == 5'd0) ? StDone : StStream;
      end
      StStream: begin
        m_valid = 1'b1;
        m_data  = beat_data;
        m_last  = beat_last;
        if (m_ready) begin
          if (beat_data) begin
            cnt_red_d = cnt_red_q + 6'd1;
          end else begin
            cnt_blue_d = cnt_blue_q + 6'd1;
          end
          if (beat_last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      ref_q      <= 1'b0;
      wait_cnt_q <= '0;
      tray_q     <= '0;
      size_q     <= '0;
      idx_q      <= '0;
      cnt_red_q  <= '0;
      cnt_blue_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      ref_q      <= ref_d;
      wait_cnt_q <= wait_cnt_d;
      tray_q     <= tray_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      cnt_red_q  <= cnt_red_d;
      cnt_blue_q <= cnt_blue_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_tray_reader.sv
// Bench for tray_reader: a queue of expected marbles (filled from the tray the
// bench presents when it signals a halt) drives a per-cycle checker; directed
// runs add literal expectations. A second instance with TIMEOUT=16 covers abort.
module tb_tray_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, stopped, m_ready;
  logic [31:0] tray;
  logic [4:0]  tray_size;
  logic        start, m_valid, m_data, m_last, busy, timeout;
  logic [5:0]  count_red, count_blue;

  logic        go2, stopped2;
  logic        start2, m_valid2, m_data2, m_last2, busy2, to2;
  logic [5:0]  cr2, cb2;

  always #5 clk = ~clk;

  tray_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .start      (start),
    .stopped    (stopped),
    .tray       (tray),
    .tray_size  (tray_size),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .count_red  (count_red),
    .count_blue (count_blue),
    .busy       (busy),
    .timeout    (timeout)
  );

  tray_reader #(.TIMEOUT(16)) dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go2),
    .start      (start2),
    .stopped    (stopped2),
    .tray       (tray),
    .tray_size  (tray_size),
    .m_valid    (m_valid2),
    .m_ready    (m_ready),
    .m_data     (m_data2),
    .m_last     (m_last2),
    .count_red  (cr2),
    .count_blue (cb2),
    .busy       (busy2),
    .timeout    (to2)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];
  int mdl_red  = 0;
  int mdl_blue = 0;
  int n_beats  = 0;
  int n_starts = 0;
  bit rdy_toggle = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_data, prev_last;
  bit valid2_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker and model update.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_red    = 0;
      mdl_blue   = 0;
      prev_stall = 1'b0;
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_count_red", int'(count_red), 0);
      chk("rst_count_blue", int'(count_blue), 0);
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_data));
        chk("stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid) begin
        chk("beat_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("beat_data", int'(m_data), int'(exp_q[0]));
          chk("beat_last", int'(m_last), int'(exp_q.size() == 1));
        end
      end
      chk("count_red", int'(count_red), mdl_red);
      chk("count_blue", int'(count_blue), mdl_blue);
      if (start) n_starts++;
      if (m_valid2) valid2_seen = 1'b1;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready && exp_q.size() != 0) begin
        if (exp_q[0]) mdl_red++;
        else mdl_blue++;
        void'(exp_q.pop_front());
        n_beats++;
      end
      // A go seen while idle is accepted at the coming edge and clears the tallies.
      if (go && !busy) begin
        mdl_red  = 0;
        mdl_blue = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_toggle) m_ready = ~m_ready;
  endtask

  // Pulse go, signal halt after 'delay' cycles, return cycles until first m_valid.
  task automatic launch(input logic [31:0] t, input logic [4:0] sz, input int delay,
                        output int lat);
    n_starts  = 0;
    n_beats   = 0;
    tray      = t;
    tray_size = sz;
    go        = 1'b1;
    step();
    go = 1'b0;
    chk("start_pulse", int'(start), 1);
    chk("busy_run", int'(busy), 1);
    step();
    chk("start_one_cycle", int'(start), 0);
    repeat (delay - 2) step();
    for (int i = 0; i < int'(sz); i++) exp_q.push_back(t[i]);
    stopped = ~stopped;
    lat = 0;
    while (!m_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      step();
      c++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int c;
    rst_n     = 1'b0;
    go        = 1'b0;
    go2       = 1'b0;
    stopped   = 1'b0;
    stopped2  = 1'b0;
    m_ready   = 1'b1;
    tray      = '0;
    tray_size = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_start", int'(start), 0);
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_m_last", int'(m_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_timeout", int'(timeout), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic run: beats 1,1,0,1; go accepted on the first edge after release.
    launch(32'b1011, 5'd4, 50, lat);
    chk("stop_to_valid", lat, 4);
    wait_idle();
    chk("run1_beats", n_beats, 4);
    chk("run1_red", int'(count_red), 3);
    chk("run1_blue", int'(count_blue), 1);
    chk("run1_starts", n_starts, 1);
    chk("run1_timeout", int'(timeout), 0);

    // Same run with back-pressure every other cycle.
    rdy_toggle = 1'b1;
    launch(32'b1011, 5'd4, 50, lat);
    wait_idle();
    rdy_toggle = 1'b0;
    m_ready    = 1'b1;
    chk("run2_beats", n_beats, 4);
    chk("run2_red", int'(count_red), 3);
    chk("run2_blue", int'(count_blue), 1);

    // Empty tray: no beats, tallies cleared.
    launch(32'hFFFF_FFFF, 5'd0, 20, lat);
    chk("size0_no_valid", int'(m_valid), 0);
    chk("size0_busy", int'(busy), 0);
    chk("size0_beats", n_beats, 0);
    chk("size0_red", int'(count_red), 0);
    chk("size0_blue", int'(count_blue), 0);

    // Full tray; inputs disturbed after capture must not matter.
    launch(32'hFFFF_FFFF, 5'd31, 10, lat);
    tray      = '0;
    tray_size = 5'd3;
    stopped   = ~stopped;
    wait_idle();
    chk("full_beats", n_beats, 31);
    chk("full_red", int'(count_red), 31);
    chk("full_blue", int'(count_blue), 0);

    // Reset in the middle of a stream.
    launch(32'h0000_00A5, 5'd8, 10, lat);
    c = 0;
    while (n_beats < 2 && c < 50) begin
      step();
      c++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(m_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_red", int'(count_red), 0);
    chk("midrst_blue", int'(count_blue), 0);
    chk("midrst_data", int'(m_data), 0);
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_valid", int'(m_valid), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Abort on the TIMEOUT=16 instance, whose stopped input never moves.
    go2 = 1'b1;
    step();
    go2 = 1'b0;
    chk("to_start", int'(start2), 1);
    c = 1;
    while (!to2 && c < 100) begin
      step();
      c++;
    end
    chk("to_cycles", c, 18);
    chk("to_flag", int'(to2), 1);
    chk("to_busy", int'(busy2), 0);
    chk("to_no_beats", int'(valid2_seen), 0);
    go2 = 1'b1;
    step();
    go2 = 1'b0;
    chk("to_cleared", int'(to2), 0);
    chk("to_restart", int'(start2), 1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
